// File: rtl/conv_window_buf.sv
// conv_window_buf: raster-order line buffer presenting kernel_dim x kernel_dim
// windows (valid padding, stride 1) to the convolution controller, holding each
// window stable until the controller has consumed it.
module conv_window_buf #(
  parameter int datatype_size  = 8,
  parameter int input_channels = 5,
  parameter int kernel_dim     = 3,
  parameter int image_width    = 8,
  parameter int image_height   = 8
) (
  input  logic                                                              clk,
  input  logic                                                              rst,
  input  logic                                                              i_valid,
  output logic                                                              o_ready,
  input  logic [input_channels-1:0][datatype_size-1:0]                      i_data,
  output logic                                                              o_start,
  input  logic                                                              i_busy,
  output logic [input_channels-1:0][kernel_dim*kernel_dim-1:0][datatype_size-1:0] o_data,
  output logic                                                              o_done
);

  localparam int unsigned DEPTH = (kernel_dim - 1) * image_width + kernel_dim;
  localparam int unsigned CW    = (image_width  > 1) ? $clog2(image_width)  : 1;
  localparam int unsigned RW    = (image_height > 1) ? $clog2(image_height) : 1;

  localparam logic [CW-1:0] COL_KM1  = CW'(kernel_dim - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(kernel_dim - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(image_width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(image_height - 1);

  typedef logic [input_channels-1:0][datatype_size-1:0] pix_t;

  typedef enum logic [1:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  pix_t          r_sr [DEPTH];
  state_t        r_state;
  logic          r_ready;
  logic          r_start;
  logic          r_done;
  logic          r_last;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic w_accept;
  logic w_win_complete;

  assign w_accept       = i_valid & r_ready;
  assign w_win_complete = (r_col >= COL_KM1) && (r_row >= ROW_KM1);

  assign o_ready = r_ready;
  assign o_start = r_start;
  assign o_done  = r_done;

  // Shift line buffer: moves only on an accepted pixel, newest pixel in entry 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else if (w_accept) begin
      r_sr[0] <= i_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  // Window tap-out: index 0 is the top-left (oldest) pixel, last index the newest
  always_comb begin
    o_data = '0;
    for (int unsigned c = 0; c < input_channels; c++) begin
      for (int unsigned ky = 0; ky < kernel_dim; ky++) begin
        for (int unsigned kx = 0; kx < kernel_dim; kx++) begin
          o_data[c][ky*kernel_dim+kx] =
            r_sr[(kernel_dim-1-ky)*image_width + (kernel_dim-1-kx)][c];
        end
      end
    end
  end

  // Handshake FSM with registered outputs plus the pixel position counters.
  // r_ready stays low in the reset FILL state until the first clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_ready <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
            if (w_win_complete) begin
              r_state <= S_START;
              r_ready <= 1'b0;
              r_start <= 1'b1;
              r_last  <= (r_col == COL_LAST) && (r_row == ROW_LAST);
            end
          end
        end
        S_START: begin
          if (i_busy) begin
            r_state <= S_WAIT;
            r_start <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!i_busy) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_FILL;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_last  <= 1'b0;
          r_col   <= '0;
          r_row   <= '0;
        end
        default: begin
          r_state <= S_FILL;
          r_ready <= 1'b0;
          r_start <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_window_buf.md
# conv_window_buf

Input window buffer directly upstream of the convolution controller. Accepts a raster-order pixel stream (all input channels per pixel) and keeps `kernel_dim-1` image rows plus `kernel_dim` pixels in a shift line buffer. At each valid kernel position (valid padding, stride 1) it presents a `kernel_dim x kernel_dim` window on `o_data` and holds it stable while the controller streams it into the CIM crossbars. It then resumes accepting pixels.

## Interface
- `datatype_size`, 8, bit width of one channel sample
- `input_channels`, 5, channels per pixel
- `kernel_dim`, 3, kernel side length; must be ≥ 2
- `image_width`, 8, pixels per row; must be ≥ `kernel_dim`
- `image_height`, 8, rows per frame; must be ≥ `kernel_dim`

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  upstream pixel valid
- `o_ready`  out  1  buffer can accept a pixel this cycle
- `i_data`  in  `[datatype_size-1:0] [input_channels-1:0]`  pixel, one sample per channel
- `o_start`  out  1  window valid; request to the controller
- `i_busy`  in  1  controller busy (its `o_busy`)
- `o_data`  out  `[datatype_size-1:0] [input_channels-1:0][kernel_dim**2-1:0]`  current window
- `o_done`  out  1  one-cycle pulse after the last window of a frame is consumed

## Operation
- Depth D = (kernel_dim-1)*image_width + kernel_dim entries of `input_channels` samples. Entry `sr[0]` is the newest pixel.
- Accept: `i_valid & o_ready`. On accept, shift `sr[d] <= sr[d-1]`, load `sr[0] <= i_data`, and advance the column/row counters (`col` wraps at `image_width-1` and increments `row`).
- Counters: `col` is `$clog2(image_width)` bits and `row` is `$clog2(image_height)` bits, both unsigned. They index the pixel being accepted.
- Window complete: an accepted pixel has `col ≥ kernel_dim-1` and `row ≥ kernel_dim-1`.
- Window mapping (combinational from `sr`):
  - `o_data[c][ky*kernel_dim+kx] = sr[(kernel_dim-1-ky)*image_width + (kernel_dim-1-kx)][c]`
  - Index 0 is the top-left of the window. The final index is the newest pixel.
- State machine:
  - FILL: `o_ready=1`. An accept that completes a window goes to START. Any other accept stays in FILL.
  - START: `o_ready=0`, `o_start=1`. When `i_busy` is sampled high, go to WAIT. Otherwise hold (no timeout).
  - WAIT: `o_ready=0`, `o_start=0`. When `i_busy` is sampled low, go to DONE if the window was the frame's last (row=H-1, col=W-1 at capture). Otherwise go to FILL.
  - DONE: `o_done=1`, `o_ready=0`, clear `col`/`row`. Go to FILL unconditionally.
- `sr` is never modified outside an accept, so `o_data` is stable from START entry until return to FILL.
- Counters are not cleared between frames except in DONE. `sr` is not cleared between frames; stale data is never exposed because the first window of a new frame needs a full refill.
- `i_valid` while `o_ready=0` is ignored. Upstream must hold `i_data`.
- Windows per frame: (W-K+1)*(H-K+1).

## Timing
- Reset (`rst=0`, asynchronous): state FILL, `col`/`row`=0, all `sr` entries 0.
  - Outputs during reset: `o_ready=0`, `o_start=0`, `o_done=0`, `o_data` all zero.
  - `o_ready=1` from the first rising edge with `rst=1`.
- Reset mid-operation (any state) aborts immediately. The current window and partial frame are discarded, and `o_start` drops asynchronously.
- `o_ready`, `o_start`, and `o_done` are decoded from the registered state only, never from `i_valid`/`i_busy`.
- Latency: a completing pixel accepted at edge N gives `o_start=1` and the valid window from cycle N+1.
  - `o_ready` falls in the same cycle.
  - The earliest next accept is the cycle after `i_busy` is sampled low (non-last window).
- Last window: a DONE cycle occurs after the WAIT exit. `o_ready` returns one cycle later than for a non-last window.
- `i_busy` already high on START entry: go to WAIT on the next edge.
- Minimum window turnaround: START(1) + WAIT(1) = 2 cycles of `o_ready=0`.

## Test plan
- Setup: W=H=4, K=3, C=2; pixel p has channel c = p + 16*c.
- Reset: drive `rst=0` mid-WAIT at pixel 11 → all outputs 0 immediately. After release, `o_ready=1`, and the first window again occurs at pixel 10.
- First window: stream pixels 0..10 with `i_busy=0` → `o_start=1` the cycle after pixel 10 is accepted. `o_ready=0`. `o_data[0]` = {0,1,2,4,5,6,8,9,10} and `o_data[1]` = each value +16.
- Handshake hold: after the first window, keep `i_busy=0` for 5 cycles → `o_start` held and `o_data` unchanged. Raise `i_busy` for 7 cycles and drop it → FILL on the edge after the drop, with `o_data` stable throughout.
- Row wrap: continue the stream → a window at pixel 11 (top-left value 1). Pixels 12 and 13 are accepted with no `o_start`. Windows follow at 14 (top-left 4) and 15 (top-left 5).
- Frame end: after the pixel-15 window is consumed → `o_done` high for exactly 1 cycle, then `o_ready=1`. A second frame with p+64 values gives its first window at pixel 10 of that frame, with top-left value 64.
- Backpressure: toggle `i_valid` randomly while `o_ready=0` → no shifts and no counter change. The window sequence is identical to the continuous-stream run.
